silife_grid_dumper: RTL and testbench

//  Read-back counterpart of the grid loader, on the same SPI-like chain. The host sends a read header; the addressed

---
 rtl/silife_grid_dumper.sv | 117 +++++++++++
 tb/tb_silife_grid_dumper.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/silife_grid_dumper.sv
// silife_grid_dumper: read-back side of the grid load chain.
// The host shifts in a read header (cmd, segment, row, dummy), and the
// addressed segment then streams grid rows LSB first on o_dump_data. Rows
// auto-increment and wrap at HEIGHT. Segments that are not addressed pass
// i_dump_data straight through so the daisy chain stays intact.
// Ports:
//   reset           async active-high reset
//   i_load_clk      load clock (rising edge)
//   i_load_cs       chip select, active-low; high clears asynchronously
//   i_load_data     serial header in
//   i_local_address this segment's chain address
//   i_dump_data     serial data from the downstream segment
//   o_dump_data     serial data toward the host
//   o_row_select    row index presented to the grid read mux
//   i_row_cells     cells of row o_row_select
//   o_active        high while this segment drives o_dump_data
module silife_grid_dumper #(
  parameter int WIDTH  = 32,
  parameter int HEIGHT = 32,
  localparam int ROW_BITS = $clog2(HEIGHT)
) (
  input  logic                reset,
  input  logic                i_load_clk,
  input  logic                i_load_cs,
  input  logic                i_load_data,
  input  logic [14:0]         i_local_address,
  input  logic                i_dump_data,
  output logic                o_dump_data,
  output logic [ROW_BITS-1:0] o_row_select,
  input  logic [WIDTH-1:0]    i_row_cells,
  output logic                o_active
);

  // The counter must reach both the 16-bit header field and WIDTH-1.
  localparam int CNT_BITS = (WIDTH > 16) ? $clog2(WIDTH) : 4;

  typedef enum logic [2:0] {
    S_IDLE, S_SEG, S_ROW, S_TURN, S_DATA, S_IGN
  } state_t;

  state_t              state, nxt;
  logic [CNT_BITS-1:0] bit_cnt;
  logic [WIDTH-1:0]    shreg;
  logic [14:0]         seg;
  logic [14:0]         row;   // bit 15 of the row field is used live on its edge

  function automatic logic [ROW_BITS-1:0] next_row(input logic [ROW_BITS-1:0] r);
    return (r == ROW_BITS'(HEIGHT - 1)) ? '0 : r + 1'b1;
  endfunction

  assign o_dump_data = o_active ? shreg[0] : i_dump_data;

  always_ff @(posedge i_load_clk or posedge reset or posedge i_load_cs) begin
    if (reset || i_load_cs) state <= S_IDLE;
    else                    state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:  nxt = i_load_data ? S_IGN : S_SEG;
      S_SEG:   if (bit_cnt == CNT_BITS'(14)) nxt = S_ROW;
      S_ROW:   if (bit_cnt == CNT_BITS'(15)) nxt = S_TURN;
      S_TURN:  nxt = S_DATA;
      default: nxt = state;
    endcase
  end

  always_ff @(posedge i_load_clk or posedge reset or posedge i_load_cs) begin
    if (reset || i_load_cs) begin
      bit_cnt      <= '0;
      shreg        <= '0;
      seg          <= '0;
      row          <= '0;
      o_row_select <= '0;
      o_active     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: bit_cnt <= '0;
        S_SEG: begin
          seg[bit_cnt[3:0]] <= i_load_data;
          bit_cnt <= (bit_cnt == CNT_BITS'(14)) ? '0 : bit_cnt + 1'b1;
        end
        S_ROW: begin
          if (bit_cnt == CNT_BITS'(15)) begin
            // Full 16-bit row field reduced modulo HEIGHT, so out-of-range rows still land somewhere valid.
            o_row_select <= ROW_BITS'({i_load_data, row} % 16'(HEIGHT));
            bit_cnt      <= '0;
          end else begin
            row[bit_cnt[3:0]] <= i_load_data;
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        S_TURN: begin
          // Preload the addressed row and point the mux at the following one,
          // so the reload at the end of each row sees its data already settled.
          shreg        <= i_row_cells;
          bit_cnt      <= '0;
          o_active     <= (seg == i_local_address);
          o_row_select <= next_row(o_row_select);
        end
        S_DATA: begin
          if (bit_cnt == CNT_BITS'(WIDTH - 1)) begin
            shreg        <= i_row_cells;
            o_row_select <= next_row(o_row_select);
            bit_cnt      <= '0;
          end else begin
            shreg   <= shreg >> 1;
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_silife_grid_dumper.sv
// Bench for silife_grid_dumper: two instances (HEIGHT 32 and 24) share the
// serial chain inputs; each sees its own row mux from a common random grid.
// Expected output bits come from indexing the grid by (row + bit/WIDTH) mod HEIGHT.
module tb_silife_grid_dumper;
  localparam int W = 32;

  logic        clk = 1'b0;
  logic        reset, cs, din, dump_in;
  logic [14:0] local_addr;
  logic        dout32, dout24, act32, act24;
  logic [4:0]  rs32, rs24;
  logic [W-1:0] cells32, cells24;
  logic [W-1:0] grid [32];

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign cells32 = grid[rs32];
  assign cells24 = grid[rs24];

  silife_grid_dumper #(.WIDTH(W), .HEIGHT(32)) dut32 (
    .reset(reset), .i_load_clk(clk), .i_load_cs(cs), .i_load_data(din),
    .i_local_address(local_addr), .i_dump_data(dump_in), .o_dump_data(dout32),
    .o_row_select(rs32), .i_row_cells(cells32), .o_active(act32));

  silife_grid_dumper #(.WIDTH(W), .HEIGHT(24)) dut24 (
    .reset(reset), .i_load_clk(clk), .i_load_cs(cs), .i_load_data(din),
    .i_local_address(local_addr), .i_dump_data(dump_in), .o_dump_data(dout24),
    .o_row_select(rs24), .i_row_cells(cells24), .o_active(act24));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one bit during the low phase, clock it, return at the next falling edge.
  task automatic step(input logic b);
    din     = b;
    dump_in = 1'($urandom);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_act32"}, {31'd0, act32}, 32'd0);
    chk({tag, "_act24"}, {31'd0, act24}, 32'd0);
    chk({tag, "_pass32"}, {31'd0, dout32}, {31'd0, dump_in});
    chk({tag, "_pass24"}, {31'd0, dout24}, {31'd0, dump_in});
  endtask

  // Full read transaction; abort_at >= 0 raises CS just before that data bit.
  task automatic do_read(input string tag, input logic [14:0] seg, input logic [15:0] row,
                         input int nbits, input int abort_at);
    logic [32:0] hdr;
    logic        sel;
    int          r0_32, r0_24, r32, r24;
    hdr   = {1'b0, row, seg, 1'b0};
    sel   = (seg == local_addr);
    r0_32 = int'(row) % 32;
    r0_24 = int'(row) % 24;
    cs = 1'b0;
    for (int i = 0; i < 32; i++) step(hdr[i]);
    chk({tag, "_turn_rs32"}, 32'(rs32), 32'(r0_32));
    chk({tag, "_turn_rs24"}, 32'(rs24), 32'(r0_24));
    for (int k = 0; k < nbits; k++) begin
      if (k == abort_at) begin
        cs = 1'b1;
        #1;
        chk({tag, "_abort_rs32"}, 32'(rs32), 32'd0);
        chk({tag, "_abort_rs24"}, 32'(rs24), 32'd0);
        check_idle({tag, "_abort"});
        return;
      end
      step((k == 0) ? 1'b0 : 1'($urandom));
      r32 = (r0_32 + k / W) % 32;
      r24 = (r0_24 + k / W) % 24;
      chk({tag, "_d32"}, {31'd0, dout32}, {31'd0, sel ? grid[r32][k % W] : dump_in});
      chk({tag, "_d24"}, {31'd0, dout24}, {31'd0, sel ? grid[r24][k % W] : dump_in});
      chk({tag, "_act32"}, {31'd0, act32}, {31'd0, sel});
      chk({tag, "_act24"}, {31'd0, act24}, {31'd0, sel});
      chk({tag, "_rs32"}, 32'(rs32), 32'((r0_32 + 1 + k / W) % 32));
      chk({tag, "_rs24"}, 32'(rs24), 32'((r0_24 + 1 + k / W) % 24));
    end
    cs = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) grid[i] = $urandom;
    grid[3]    = 32'h8000_00A5;
    reset      = 1'b1;
    cs         = 1'b1;
    din        = 1'b0;
    dump_in    = 1'b1;
    local_addr = 15'd5;
    #1;
    chk("reset_rs32", 32'(rs32), 32'd0);
    chk("reset_rs24", 32'(rs24), 32'd0);
    check_idle("reset");
    @(negedge clk);
    reset = 1'b0;

    // Edges with CS high must leave everything idle.
    for (int i = 0; i < 3; i++) step(1'($urandom));
    check_idle("cs_high");

    do_read("rd_a5", 15'd5, 16'd3, 32, -1);
    local_addr = 15'd6;
    do_read("rd_miss", 15'd5, 16'd3, 32, -1);
    local_addr = 15'h2A5C;
    do_read("wrap31", 15'h2A5C, 16'd31, 64, -1);
    do_read("wrap23", 15'h2A5C, 16'd23, 64, -1);
    do_read("row_b15", 15'h2A5C, 16'h8003, 40, -1);

    // Non-read command: ignored for the rest of the CS window.
    cs = 1'b0;
    step(1'b1);
    for (int i = 0; i < 40; i++) begin
      step(1'($urandom));
      check_idle("ignore");
    end
    cs = 1'b1;
    @(negedge clk);
    do_read("after_ign", 15'h2A5C, 16'd9, 32, -1);

    do_read("abort", 15'h2A5C, 16'd12, 32, 10);
    @(negedge clk);
    do_read("after_abort", 15'h2A5C, 16'd7, 32, -1);

    for (int n = 0; n < 4; n++) begin
      logic [14:0] s;
      s = ($urandom_range(0, 2) == 0) ? 15'($urandom) : local_addr;
      do_read("random", s, 16'($urandom), 48, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
